radar_roi_scanner: RTL and testbench
====================================

# radar_roi_scanner

Region-of-interest pixel scanner for the radar image path. On a start request it walks a rectangular window of a 64×64 single-channel frame in raster order and emits one pixel code per clock. It flags the last pixel with `data_end`. It sits between the radar control interface (which supplies window corners and channel) and downstream pixel consumers.

## Interface
Parameters: none; all widths are fixed.

- `clk` input 1: single system clock; all logic is on the rising edge.
- `rst_n` input 1: synchronous, active-high reset. The port keeps the codebase name; asserted = 1.
- `row_idx1` input 6: first corner row.
- `col_idx1` input 6: first corner column.
- `row_idx2` input 6: second corner row.
- `col_idx2` input 6: second corner column.
- `channel_num` input 4: radar channel tag, embedded in every pixel.
- `data_start` input 1: start request, sampled only when idle.
- `data_end` output 1: registered; high exactly on the cycle the last pixel of a window is on `pixel_out`.
- `pixel_out` output 16: registered pixel code `{channel[3:0], row[5:0], col[5:0]}`; 0 when idle.

## Operation
- The FSM has two states, IDLE and SCAN.
- IDLE, when `data_start`=1:
  - latch `channel_num`;
  - latch normalized corners `rmin=min(row_idx1,row_idx2)`, `rmax=max(...)`, `cmin`, `cmax` likewise;
  - load the scan position (`rmin`, `cmin`);
  - go to SCAN.
- Inputs are ignored except at that sampling edge; later changes do not affect an active scan.
- SCAN: each cycle drive `pixel_out={ch,row,col}` for the current position, then advance.
  - Advance `col` first; on `col==cmax`, wrap `col` to `cmin` and increment `row`.
  - When `row==rmax` and `col==cmax`, assert `data_end` with that pixel and return to IDLE.
- Pixel count N = (rmax−rmin+1)·(cmax−cmin+1), range 1..4096. Use a 13-bit counter or equivalent position compare.
- `data_start` while in SCAN, including the `data_end` cycle, is ignored; no queuing.
- If `data_start` is held high, a new scan starts at the first IDLE sample.
- A degenerate window (equal corners) yields exactly one pixel with `data_end`=1.
- In IDLE, `pixel_out`=0 and `data_end`=0.

## Timing
- Reset (`rst_n`=1 at an edge): state IDLE, `pixel_out`=0, `data_end`=0, latched registers cleared. Reset overrides `data_start`.
- Reset mid-scan aborts the scan on that edge and does not produce `data_end`.
- `data_start` sampled high at edge T (IDLE): pixel k (k=0..N−1) is valid after edge T+1+k.
- `data_end`=1 only after edge T+N. After edge T+N+1, outputs return to 0.
- Earliest next accepted start is edge T+N+1, giving a first pixel at T+N+2. The minimum gap between windows is one idle cycle.
- Valid-pixel window: from the cycle after the start is accepted through the `data_end` cycle inclusive. There is no separate valid strobe.

## Configuration
- `RADAR_ROI_SNAKE_SCAN_EN` defined: serpentine scan.
  - Rows at offset (row−rmin) odd are traversed from `cmax` down to `cmin`; even-offset rows go from `cmin` up to `cmax`.
  - The last pixel is (`rmax`,`cmin`) when the row count is even, otherwise (`rmax`,`cmax`).
  - `data_end` timing and N are unchanged.
- Undefined (default): plain raster, every row `cmin`→`cmax`.

## Test plan
- Single pixel: corners (5,7),(5,7), ch=3, start at T -> `pixel_out`=0x3147 with `data_end`=1 at T+1; 0/0 at T+2.
- 2×2 window: (1,2),(2,3), ch=1 -> 0x1042, 0x1043, 0x1082, 0x1083 at T+1..T+4, with `data_end` only at T+4. With `RADAR_ROI_SNAKE_SCAN_EN`: 0x1042, 0x1043, 0x1083, 0x1082.
- Swapped corners (2,3),(1,2), ch=1 -> output identical to the previous case.
- Full frame (0,0),(63,63), ch=15 -> 4096 pixels, first 0xF000, last 0xFFFF with `data_end` at T+4096.
- Busy/back-to-back: `data_start` held high through a 2×2 scan -> the second scan's first pixel appears at T+6, with no truncation of the first.
- Reset mid-scan: `rst_n`=1 at T+2 of a 2×2 scan -> from T+3 `pixel_out`=0 and `data_end` never asserts. A new start after reset behaves normally.

Source files
------------

// File: rtl/radar_roi_scanner_if.sv
// Control/pixel bundle for radar_roi_scanner: window corners, channel tag and
// start request in, registered pixel code and end-of-window flag out.
interface radar_roi_scanner_if;
    logic [5:0]  row_idx1;
    logic [5:0]  col_idx1;
    logic [5:0]  row_idx2;
    logic [5:0]  col_idx2;
    logic [3:0]  channel_num;
    logic        data_start;
    logic        data_end;
    logic [15:0] pixel_out;

    modport master (
        output row_idx1, col_idx1, row_idx2, col_idx2, channel_num, data_start,
        input  data_end, pixel_out
    );

    modport slave (
        input  row_idx1, col_idx1, row_idx2, col_idx2, channel_num, data_start,
        output data_end, pixel_out
    );
endinterface

// File: rtl/radar_roi_scanner.sv
// Region-of-interest raster scanner over a 64x64 frame, one pixel code per clock.
// Define RADAR_ROI_SNAKE_SCAN_EN for serpentine row traversal.
module radar_roi_scanner (
    input  logic                 clk,
    input  logic                 rst_n,
    radar_roi_scanner_if.slave   bus
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t      state;
    logic [3:0]  ch;
    logic [5:0]  rmin, rmax, cmin, cmax;
    logic [5:0]  row, col;
    logic [15:0] pixel_q;
    logic        end_q;
    logic [5:0]  row_end_col;
    logic        at_row_end;
    logic        at_last;
`ifdef RADAR_ROI_SNAKE_SCAN_EN
    logic        rev;
`endif

    function automatic logic [5:0] min6(input logic [5:0] a, input logic [5:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [5:0] max6(input logic [5:0] a, input logic [5:0] b);
        return (a < b) ? b : a;
    endfunction

    // The column a row finishes on depends on traversal direction in serpentine mode.
    always_comb begin
`ifdef RADAR_ROI_SNAKE_SCAN_EN
        row_end_col = rev ? cmin : cmax;
`else
        row_end_col = cmax;
`endif
        at_row_end = (col == row_end_col);
        at_last    = at_row_end && (row == rmax);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state   <= IDLE;
            pixel_q <= '0;
            end_q   <= 1'b0;
            ch      <= '0;
            rmin    <= '0;
            rmax    <= '0;
            cmin    <= '0;
            cmax    <= '0;
            row     <= '0;
            col     <= '0;
`ifdef RADAR_ROI_SNAKE_SCAN_EN
            rev     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    pixel_q <= '0;
                    end_q   <= 1'b0;
                    if (bus.data_start) begin
                        ch    <= bus.channel_num;
                        rmin  <= min6(bus.row_idx1, bus.row_idx2);
                        rmax  <= max6(bus.row_idx1, bus.row_idx2);
                        cmin  <= min6(bus.col_idx1, bus.col_idx2);
                        cmax  <= max6(bus.col_idx1, bus.col_idx2);
                        row   <= min6(bus.row_idx1, bus.row_idx2);
                        col   <= min6(bus.col_idx1, bus.col_idx2);
`ifdef RADAR_ROI_SNAKE_SCAN_EN
                        rev   <= 1'b0;
`endif
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    pixel_q <= {ch, row, col};
                    end_q   <= at_last;
                    if (at_last) begin
                        state <= IDLE;
                    end else if (at_row_end) begin
                        row <= row + 6'd1;
`ifdef RADAR_ROI_SNAKE_SCAN_EN
                        // Next row starts on the same column, walking the other way.
                        rev <= ~rev;
`else
                        col <= cmin;
`endif
                    end else begin
`ifdef RADAR_ROI_SNAKE_SCAN_EN
                        col <= rev ? (col - 6'd1) : (col + 6'd1);
`else
                        col <= col + 6'd1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pixel_out = pixel_q;
    assign bus.data_end  = end_q;

endmodule

// File: tb/tb_radar_roi_scanner.sv
// Scoreboard bench for radar_roi_scanner: expected per-cycle pixel codes are queued
// at start time and checked every cycle on the falling edge (idle cycles expect 0/0).
module tb_radar_roi_scanner;

    logic clk;
    logic rst_n;
    int unsigned cyc;
    bit mon_en;
    int compared;
    int mismatched;

    typedef struct {
        int unsigned cyc;
        logic [15:0] pix;
        logic        last;
    } exp_t;

    exp_t q[$];

    radar_roi_scanner_if bus ();

    radar_roi_scanner dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Build the expected pixel stream of one window starting at accept edge t.
    task automatic push_window(input int r1, input int c1, input int r2, input int c2,
                               input int ch, input int unsigned t);
        int rmn, rmx, cmn, cmx, w, n, k, c;
        rmn = (r1 < r2) ? r1 : r2;
        rmx = (r1 < r2) ? r2 : r1;
        cmn = (c1 < c2) ? c1 : c2;
        cmx = (c1 < c2) ? c2 : c1;
        w = cmx - cmn + 1;
        n = (rmx - rmn + 1) * w;
        k = 0;
        for (int r = rmn; r <= rmx; r++) begin
            for (int j = 0; j < w; j++) begin
                exp_t e;
`ifdef RADAR_ROI_SNAKE_SCAN_EN
                c = (((r - rmn) % 2) == 1) ? (cmx - j) : (cmn + j);
`else
                c = cmn + j;
`endif
                e.cyc  = t + 1 + k;
                e.pix  = {4'(ch), 6'(r), 6'(c)};
                e.last = (k == n - 1);
                q.push_back(e);
                k++;
            end
        end
    endtask

    task automatic set_inputs(input int r1, input int c1, input int r2, input int c2,
                              input int ch);
        bus.row_idx1    = 6'(r1);
        bus.col_idx1    = 6'(c1);
        bus.row_idx2    = 6'(r2);
        bus.col_idx2    = 6'(c2);
        bus.channel_num = 4'(ch);
    endtask

    // Drive one start pulse, then scramble inputs to show they are ignored mid-scan.
    task automatic launch(input int r1, input int c1, input int r2, input int c2,
                          input int ch, output int unsigned t);
        @(negedge clk);
        set_inputs(r1, c1, r2, c2, ch);
        bus.data_start = 1'b1;
        t = cyc + 1;
        push_window(r1, c1, r2, c2, ch, t);
        @(negedge clk);
        bus.data_start = 1'b0;
        set_inputs($urandom_range(63), $urandom_range(63), $urandom_range(63),
                   $urandom_range(63), $urandom_range(15));
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        compared++;
        assert (q.size() == 0) else begin
            mismatched++;
            $error("FAIL timeout: %0d expected pixels still pending, required 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin : monitor
            logic [15:0] ep;
            logic        el;
            exp_t        e;
            ep = '0;
            el = 1'b0;
            if (q.size() != 0 && q[0].cyc == cyc) begin
                e  = q.pop_front();
                ep = e.pix;
                el = e.last;
            end
            compared++;
            assert (bus.pixel_out === ep) else begin
                mismatched++;
                $error("FAIL pixel_out cyc=%0d observed=%h expected=%h", cyc, bus.pixel_out, ep);
            end
            compared++;
            assert (bus.data_end === el) else begin
                mismatched++;
                $error("FAIL data_end cyc=%0d observed=%b expected=%b", cyc, bus.data_end, el);
            end
        end
    end

    initial begin
        int unsigned t;
        exp_t keep[$];
        cyc        = 0;
        compared   = 0;
        mismatched = 0;
        mon_en     = 1'b0;
        rst_n      = 1'b1;
        set_inputs(5, 7, 5, 7, 3);
        bus.data_start = 1'b1;          // reset must override a pending start
        @(posedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        bus.data_start = 1'b0;
        repeat (2) @(negedge clk);

        // single pixel
        launch(5, 7, 5, 7, 3, t);
        compared++;
        assert (q.size() == 1 && q[0].pix === 16'h3147) else begin
            mismatched++;
            $error("FAIL single_model observed=%0d entries required=1 at 3147", q.size());
        end
        wait_done(20);

        // 2x2, then swapped corners
        launch(1, 2, 2, 3, 1, t);
        wait_done(20);
        launch(2, 3, 1, 2, 1, t);
        wait_done(20);

        // non-square windows with random channel
        launch(10, 60, 12, 57, $urandom_range(1, 15), t);
        wait_done(50);
        launch(40, 3, 33, 3, $urandom_range(1, 15), t);
        wait_done(50);
        launch(63, 0, 63, 63, $urandom_range(1, 15), t);
        wait_done(100);

        // start held high through two back-to-back 2x2 scans
        @(negedge clk);
        set_inputs(1, 2, 2, 3, 1);
        bus.data_start = 1'b1;
        t = cyc + 1;
        push_window(1, 2, 2, 3, 1, t);
        push_window(1, 2, 2, 3, 1, t + 5);
        while (cyc < t + 5) @(negedge clk);
        bus.data_start = 1'b0;
        wait_done(30);

        // reset asserted for the edge T+2 of a 2x2 scan
        launch(1, 2, 2, 3, 1, t);
        @(negedge clk);
        rst_n = 1'b1;
        keep = {};
        foreach (q[i]) if (q[i].cyc < t + 2) keep.push_back(q[i]);
        q = keep;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (6) @(negedge clk);
        launch(8, 9, 9, 8, 6, t);
        wait_done(20);

        // full frame
        launch(0, 0, 63, 63, 15, t);
        compared++;
        assert (q.size() == 4096 && q[0].pix === 16'hF000 && q[4095].pix === 16'hFFFF
                && q[4095].cyc == t + 4096) else begin
            mismatched++;
            $error("FAIL full_model observed=%0d entries required=4096", q.size());
        end
        wait_done(5000);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
